// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, funct codes, ALU operations and register names shared by the CPU.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_V0   = 5'd2;
  localparam logic [4:0] REG_A0   = 5'd4;
  localparam logic [4:0] REG_A1   = 5'd5;
  localparam logic [4:0] REG_T0   = 5'd8;
  localparam logic [4:0] REG_S0   = 5'd16;
  localparam logic [4:0] REG_S1   = 5'd17;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two combinational reads, one clocked write; $0 is hardwired to zero.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [32];
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != REG_ZERO)
      regs[wa] <= wd;
  assign rd1 = (ra1 == REG_ZERO) ? '0 : regs[ra1];
  assign rd2 = (ra2 == REG_ZERO) ? '0 : regs[ra2];
endmodule

// File: rtl/mips_single_cycle_cpu.sv
// mips_single_cycle_cpu: single-cycle MIPS-I subset core with byte-addressed instruction/data memories.
// Define MIPS_TRACE_EN to print a per-cycle trace of PC, instruction and register/memory writes.
module mips_single_cycle_cpu
  import mips_pkg::*;
#(
  parameter int          IMEM_BYTES = 1024,
  parameter int          DMEM_BYTES = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);
  localparam int IA = $clog2(IMEM_BYTES);
  localparam int DA = $clog2(DMEM_BYTES);
  logic [7:0] imem [IMEM_BYTES];
  logic [7:0] dmem [DMEM_BYTES];
  logic [31:0] pc, instr, pc_plus4, next_pc, imm_ext, rs_val, rt_val, alu_b, alu_y, load_val, wd;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt, wa;
  logic [15:0] imm;
  logic [DA-1:0] da;
  alu_op_t alu_op;
  logic use_imm, zext, reg_we, mem_we, mem_rd, is_beq, is_bne, is_j, is_jal, is_jr, dst_rt;
  // Bytes beyond the instruction store read as zero so running off the end executes NOPs.
  function automatic logic [7:0] ibyte(input logic [31:0] a);
    return (a < 32'(IMEM_BYTES)) ? imem[IA'(a)] : 8'h00;
  endfunction
  assign instr = {ibyte(pc), ibyte(pc + 32'd1), ibyte(pc + 32'd2), ibyte(pc + 32'd3)};
  assign {op, rs, rt, rd, shamt, funct} = instr;
  assign imm = instr[15:0];
  assign pc_o = pc;
  assign instr_o = instr;
  always_comb begin
    alu_op = ALU_ADD;
    use_imm = 1'b0;
    zext = 1'b0;
    reg_we = 1'b0;
    dst_rt = 1'b0;
    mem_we = 1'b0;
    mem_rd = 1'b0;
    is_beq = 1'b0;
    is_bne = 1'b0;
    is_j = 1'b0;
    is_jal = 1'b0;
    is_jr = 1'b0;
    case (op)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_JR: begin
            reg_we = 1'b0;
            is_jr = 1'b1;
          end
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: {reg_we, dst_rt, use_imm} = 3'b111;
      OP_SLTI:  {reg_we, dst_rt, use_imm, alu_op} = {3'b111, ALU_SLT};
      OP_SLTIU: {reg_we, dst_rt, use_imm, alu_op} = {3'b111, ALU_SLTU};
      OP_ANDI:  {reg_we, dst_rt, use_imm, zext, alu_op} = {4'b1111, ALU_AND};
      OP_ORI:   {reg_we, dst_rt, use_imm, zext, alu_op} = {4'b1111, ALU_OR};
      OP_XORI:  {reg_we, dst_rt, use_imm, zext, alu_op} = {4'b1111, ALU_XOR};
      OP_LUI:   {reg_we, dst_rt, use_imm, alu_op} = {3'b111, ALU_LUI};
      OP_LW:    {reg_we, dst_rt, use_imm, mem_rd} = 4'b1111;
      OP_SW:    {use_imm, mem_we} = 2'b11;
      OP_BEQ:   is_beq = 1'b1;
      OP_BNE:   is_bne = 1'b1;
      OP_J:     is_j = 1'b1;
      OP_JAL:   {is_j, is_jal, reg_we} = 3'b111;
      default: ;
    endcase
  end
  mips_regfile u_rf (
    .clk(clk), .reset(reset),
    .ra1(rs), .ra2(rt), .rd1(rs_val), .rd2(rt_val),
    .we(reg_we), .wa(wa), .wd(wd)
  );
  assign imm_ext = zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  assign alu_b = use_imm ? imm_ext : rt_val;
  // Shifts take their operand from rt and their amount from shamt, matching MIPS encoding.
  always_comb begin
    case (alu_op)
      ALU_SUB:  alu_y = rs_val - alu_b;
      ALU_AND:  alu_y = rs_val & alu_b;
      ALU_OR:   alu_y = rs_val | alu_b;
      ALU_XOR:  alu_y = rs_val ^ alu_b;
      ALU_NOR:  alu_y = ~(rs_val | alu_b);
      ALU_SLT:  alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'd0, rs_val < alu_b};
      ALU_SLL:  alu_y = alu_b << shamt;
      ALU_SRL:  alu_y = alu_b >> shamt;
      ALU_SRA:  alu_y = $signed(alu_b) >>> shamt;
      ALU_LUI:  alu_y = {alu_b[15:0], 16'h0000};
      default:  alu_y = rs_val + alu_b;
    endcase
  end
  assign da = DA'(alu_y);
  assign load_val = {dmem[da], dmem[da + DA'(1)], dmem[da + DA'(2)], dmem[da + DA'(3)]};
  always_ff @(posedge clk)
    if (mem_we && !reset) begin
      dmem[da]         <= rt_val[31:24];
      dmem[da + DA'(1)] <= rt_val[23:16];
      dmem[da + DA'(2)] <= rt_val[15:8];
      dmem[da + DA'(3)] <= rt_val[7:0];
    end
  assign wa = is_jal ? REG_RA : dst_rt ? rt : rd;
  assign wd = is_jal ? pc_plus4 : mem_rd ? load_val : alu_y;
  assign pc_plus4 = pc + 32'd4;
  assign next_pc = is_jr ? rs_val
                 : is_j ? {pc_plus4[31:28], instr[25:0], 2'b00}
                 : ((is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val)) ? pc_plus4 + {imm_ext[29:0], 2'b00}
                 : pc_plus4;
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= RESET_PC;
    else pc <= next_pc;
`ifdef MIPS_TRACE_EN
  always @(posedge clk)
    if (!reset) begin
      $display("pc=%08h instr=%08h", pc, instr);
      if (reg_we && wa != REG_ZERO) $display("  r%0d <= %08h", wa, wd);
      if (mem_we) $display("  mem[%08h] <= %08h", alu_y, rt_val);
    end
`else
`endif
endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// tb_mips_single_cycle_cpu: directed programs with hand-computed register, PC and memory expectations.
module tb_mips_single_cycle_cpu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] pc_o, instr_o;
  int n_chk = 0;
  int n_bad = 0;
  mips_single_cycle_cpu dut (.clk(clk), .reset(reset), .pc_o(pc_o), .instr_o(instr_o));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rt_(input int fn, input int rs, input int rt, input int rd, input int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] it_(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] jt_(input int op, input int addr);
    return {6'(op), 26'(addr >> 2)};
  endfunction
  function automatic logic [31:0] r(input int k);
    return dut.u_rf.regs[k];
  endfunction
  task automatic wr(input int addr, input logic [31:0] w);
    dut.imem[addr]     = w[31:24];
    dut.imem[addr + 1] = w[23:16];
    dut.imem[addr + 2] = w[15:8];
    dut.imem[addr + 3] = w[7:0];
  endtask
  task automatic begin_prog();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) dut.imem[i] = 8'h00;
  endtask
  task automatic run_prog();
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  logic [31:0] acc;
  initial begin
    // ALU program
    begin_prog();
    wr(32'h00, it_(8, 0, 4, 16'hFFFF));
    wr(32'h04, rt_(8'h2B, 0, 4, 8, 0));
    wr(32'h08, it_(8'h0F, 0, 5, 16'h1234));
    wr(32'h0C, it_(8'h0D, 5, 5, 16'h5678));
    wr(32'h10, it_(8, 0, 0, 16'd5));
    wr(32'h14, rt_(8'h22, 5, 4, 16, 0));
    wr(32'h18, rt_(2, 0, 5, 17, 4));
    wr(32'h1C, rt_(8'h2A, 4, 0, 2, 0));
    wr(32'h20, rt_(8'h27, 5, 0, 29, 0));
    wr(32'h24, it_(8'h0E, 5, 8, 16'hFFFF));
    #1;
    chk("reset_pc", pc_o, 32'h0);
    chk("reset_instr", instr_o, 32'h2004FFFF);
    run_prog();
    step(1); chk("addi_a0", r(4), 32'hFFFFFFFF);
    step(1); chk("sltu_t0", r(8), 32'h1);
    step(2); chk("lui_ori_a1", r(5), 32'h12345678);
    step(1); chk("zero_protect", r(0), 32'h0);
    step(1); chk("sub_s0", r(16), 32'h12345679);
    step(1); chk("srl_s1", r(17), 32'h01234567);
    step(1); chk("slt_v0", r(2), 32'h1);
    step(1); chk("nor_sp", r(29), 32'hEDCBA987);
    step(1); chk("xori_t0", r(8), 32'h1234A987);
    chk("alu_pc", pc_o, 32'h28);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_pc", pc_o, 32'h0);
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= r(i);
    chk("midreset_regs", acc, 32'h0);
    // jal / jr program
    begin_prog();
    wr(32'h00, it_(8, 0, 5, 16'd2));
    wr(32'h04, jt_(3, 32'h10));
    wr(32'h08, it_(8, 0, 4, 16'd9));
    wr(32'h0C, 32'h0);
    wr(32'h10, it_(8, 4, 4, 16'd4));
    wr(32'h14, it_(8, 0, 17, 16'd29));
    wr(32'h18, rt_(8, 31, 0, 0, 0));
    run_prog();
    step(2);
    chk("jal_a0", r(4), 32'h0);
    chk("jal_a1", r(5), 32'h2);
    chk("jal_ra", r(31), 32'h8);
    chk("jal_pc", pc_o, 32'h10);
    step(3);
    chk("jr_pc", pc_o, 32'h8);
    chk("s1", r(17), 32'd29);
    chk("a0_before", r(4), 32'h4);
    step(1); chk("a0_after_jr", r(4), 32'h9);
    // branch program
    begin_prog();
    wr(32'h00, it_(8, 0, 8, 16'd1));
    wr(32'h04, it_(5, 0, 0, 16'd5));
    wr(32'h08, it_(4, 0, 0, 16'd1));
    wr(32'h0C, it_(8, 0, 16, 16'd7));
    wr(32'h10, it_(4, 0, 0, 16'hFFFF));
    run_prog();
    step(2); chk("bne_not_taken", pc_o, 32'h8);
    step(1); chk("beq_taken", pc_o, 32'h10);
    chk("beq_instr", instr_o, 32'h1000FFFF);
    for (int i = 0; i < 3; i++) begin
      step(1); chk("beq_loop_pc", pc_o, 32'h10);
    end
    chk("skipped_s0", r(16), 32'h0);
    // memory, j and unknown-opcode program
    begin_prog();
    wr(32'h00, it_(8'h0F, 0, 5, 16'hA1B2));
    wr(32'h04, it_(8'h0D, 5, 5, 16'hC3D4));
    wr(32'h08, it_(8'h2B, 0, 5, 16'd8));
    wr(32'h0C, it_(8'h23, 0, 8, 16'd8));
    wr(32'h10, jt_(2, 32'h18));
    wr(32'h14, it_(8, 0, 17, 16'd1));
    wr(32'h18, it_(8, 8, 2, 16'd0));
    wr(32'h1C, {6'h3F, 5'd0, 5'd16, 16'h0001});
    run_prog();
    step(3);
    chk("sw_byte8", {24'd0, dut.dmem[8]}, 32'hA1);
    chk("sw_byte11", {24'd0, dut.dmem[11]}, 32'hD4);
    step(1); chk("lw_t0", r(8), 32'hA1B2C3D4);
    step(1); chk("j_pc", pc_o, 32'h18);
    step(1);
    chk("j_skipped_s1", r(17), 32'h0);
    chk("addi_v0", r(2), 32'hA1B2C3D4);
    step(1);
    chk("unknown_pc", pc_o, 32'h20);
    chk("unknown_nowrite", r(16), 32'h0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
